// File: rtl/uart_msg_framer.sv
// Length-prefixed message framer: packs UART payload bytes into big-endian 32-bit words
// for a valid/ready consumer, flagging bad lengths, inter-byte timeouts and output overruns.
`timescale 1ns/1ps

module uart_msg_framer #(
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter int unsigned MAX_LEN        = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        word_last,
    output logic [2:0]  word_bytes,
    output logic [7:0]  msg_len,
    output logic        word_abort,
    output logic        busy,
    output logic        err_len,
    output logic        err_timeout,
    output logic        err_overflow
);

    localparam int unsigned TmoW    = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned TmoLast = TIMEOUT_CYCLES - 1;
    localparam logic [TmoW-1:0] TmoMax = TmoLast[TmoW-1:0];
    localparam logic [7:0] MaxLen = MAX_LEN[7:0];

    typedef enum logic [0:0] {StIdle, StPayload} state_e;

    state_e state_q, state_d;

    logic [7:0]      remaining_q, remaining_d;
    logic [31:0]     acc_q, acc_d;
    logic [1:0]      acc_cnt_q, acc_cnt_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [31:0]     word_data_q, word_data_d;
    logic            word_valid_q, word_valid_d;
    logic            word_last_q, word_last_d;
    logic [2:0]      word_bytes_q, word_bytes_d;
    logic [7:0]      msg_len_q, msg_len_d;
    logic            word_abort_q, word_abort_d;
    logic            err_len_q, err_len_d;
    logic            err_timeout_q, err_timeout_d;
    logic            err_overflow_q, err_overflow_d;

    logic        len_bad;
    logic        word_done;
    logic        overflow;
    logic        tmo_hit;
    logic        last_byte;
    logic [31:0] acc_new;

    assign len_bad   = (rx_data == 8'd0) || (rx_data > MaxLen);
    assign last_byte = (remaining_q == 8'd1);
    assign word_done = (acc_cnt_q == 2'd3) || last_byte;
    assign overflow  = word_valid_q && !word_ready;
    assign tmo_hit   = (tmo_q == TmoMax);

    // Accumulator with the incoming byte placed in its big-endian lane.
    always_comb begin
        acc_new = acc_q;
        unique case (acc_cnt_q)
            2'd0: acc_new[31:24] = rx_data;
            2'd1: acc_new[23:16] = rx_data;
            2'd2: acc_new[15:8]  = rx_data;
            2'd3: acc_new[7:0]   = rx_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (rx_valid && !len_bad) state_d = StPayload;
            end
            StPayload: begin
                if (rx_valid) begin
                    if (word_done && (overflow || last_byte)) state_d = StIdle;
                end else if (tmo_hit) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_comb begin
        remaining_d    = remaining_q;
        acc_d          = acc_q;
        acc_cnt_d      = acc_cnt_q;
        tmo_d          = tmo_q;
        word_data_d    = word_data_q;
        word_valid_d   = word_valid_q;
        word_last_d    = word_last_q;
        word_bytes_d   = word_bytes_q;
        msg_len_d      = msg_len_q;
        word_abort_d   = 1'b0;
        err_len_d      = 1'b0;
        err_timeout_d  = 1'b0;
        err_overflow_d = 1'b0;

        if (word_valid_q && word_ready) word_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    if (len_bad) begin
                        err_len_d = 1'b1;
                    end else begin
                        msg_len_d   = rx_data;
                        remaining_d = rx_data;
                        acc_d       = '0;
                        acc_cnt_d   = '0;
                        tmo_d       = '0;
                    end
                end
            end
            StPayload: begin
                if (rx_valid) begin
                    remaining_d = remaining_q - 8'd1;
                    tmo_d       = '0;
                    if (word_done) begin
                        acc_d     = '0;
                        acc_cnt_d = '0;
                        if (overflow) begin
                            // Output register still full: drop both words, abort message.
                            err_overflow_d = 1'b1;
                            word_abort_d   = 1'b1;
                            word_valid_d   = 1'b0;
                        end else begin
                            word_data_d  = acc_new;
                            word_valid_d = 1'b1;
                            word_bytes_d = {1'b0, acc_cnt_q} + 3'd1;
                            word_last_d  = last_byte;
                        end
                    end else begin
                        acc_d     = acc_new;
                        acc_cnt_d = acc_cnt_q + 2'd1;
                    end
                end else if (tmo_hit) begin
                    err_timeout_d = 1'b1;
                    word_abort_d  = 1'b1;
                    word_valid_d  = 1'b0;
                    acc_d         = '0;
                    acc_cnt_d     = '0;
                    tmo_d         = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            remaining_q    <= '0;
            acc_q          <= '0;
            acc_cnt_q      <= '0;
            tmo_q          <= '0;
            word_data_q    <= '0;
            word_valid_q   <= 1'b0;
            word_last_q    <= 1'b0;
            word_bytes_q   <= '0;
            msg_len_q      <= '0;
            word_abort_q   <= 1'b0;
            err_len_q      <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            remaining_q    <= remaining_d;
            acc_q          <= acc_d;
            acc_cnt_q      <= acc_cnt_d;
            tmo_q          <= tmo_d;
            word_data_q    <= word_data_d;
            word_valid_q   <= word_valid_d;
            word_last_q    <= word_last_d;
            word_bytes_q   <= word_bytes_d;
            msg_len_q      <= msg_len_d;
            word_abort_q   <= word_abort_d;
            err_len_q      <= err_len_d;
            err_timeout_q  <= err_timeout_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign word_data    = word_data_q;
    assign word_valid   = word_valid_q;
    assign word_last    = word_last_q;
    assign word_bytes   = word_bytes_q;
    assign msg_len      = msg_len_q;
    assign word_abort   = word_abort_q;
    assign busy         = (state_q == StPayload);
    assign err_len      = err_len_q;
    assign err_timeout  = err_timeout_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_uart_msg_framer.sv
// Self-checking bench for uart_msg_framer: directed frames plus randomized messages
// compared against a byte-chunking reference model.
`timescale 1ns/1ps

module tb_uart_msg_framer;

    localparam int unsigned T    = 40;
    localparam int unsigned MAXL = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        word_ready = 1'b0;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_last;
    logic [2:0]  word_bytes;
    logic [7:0]  msg_len;
    logic        word_abort;
    logic        busy;
    logic        err_len;
    logic        err_timeout;
    logic        err_overflow;

    uart_msg_framer #(
        .TIMEOUT_CYCLES(T),
        .MAX_LEN       (MAXL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .word_last   (word_last),
        .word_bytes  (word_bytes),
        .msg_len     (msg_len),
        .word_abort  (word_abort),
        .busy        (busy),
        .err_len     (err_len),
        .err_timeout (err_timeout),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_abort = 0;
    int n_len = 0;
    int n_tmo = 0;
    int n_ovf = 0;

    // Entries are {data[31:0], bytes[2:0], last}.
    logic [35:0] got_q[$];
    logic [35:0] exp_q[$];
    logic [7:0]  payload[256];
    logic        hold_prev = 1'b0;
    logic [35:0] held = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs of a stalled word must not move unless the message is aborted.
    always @(negedge clk) begin
        if (hold_prev && !word_abort)
            chk("hold_stable", {word_valid, word_data, word_bytes, word_last}, {1'b1, held});
        hold_prev <= word_valid && !word_ready && !reset;
        held      <= {word_data, word_bytes, word_last};
        if (word_valid && word_ready) got_q.push_back({word_data, word_bytes, word_last});
        if (word_abort)   n_abort <= n_abort + 1;
        if (err_len)      n_len   <= n_len + 1;
        if (err_timeout)  n_tmo   <= n_tmo + 1;
        if (err_overflow) n_ovf   <= n_ovf + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Reference: chop the payload into 4-byte big-endian chunks, last chunk may be short.
    task automatic model_msg(input int len);
        for (int i = 0; i < len; i += 4) begin
            logic [31:0] w;
            int n;
            w = '0;
            n = (len - i < 4) ? len - i : 4;
            for (int j = 0; j < n; j++) w = w | (32'(payload[i + j]) << (24 - 8 * j));
            exp_q.push_back({w, 3'(n), (i + 4 >= len)});
        end
    endtask

    task automatic compare_queues(input string tag);
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk(tag, 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lens[8];
        int len;
        int k;
        int base_len, base_tmo, base_ovf, base_abort;

        tick(3);
        reset = 1'b0;
        chk("reset_vals", {word_data, word_valid, word_last, word_bytes, msg_len, word_abort,
                           busy, err_len, err_timeout, err_overflow}, 64'd0);

        // Basic 5-byte frame with consumer always ready.
        word_ready = 1'b1;
        got_q.delete();
        send_byte(8'h05);
        chk("busy_after_len", busy, 1'b1);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        chk("w0_latency", {word_valid, word_data, word_bytes, word_last},
            {1'b1, 32'h11223344, 3'd4, 1'b0});
        send_byte(8'h55);
        chk("w1_latency", {word_valid, word_data, word_bytes, word_last},
            {1'b1, 32'h55000000, 3'd1, 1'b1});
        chk("busy_after_last", busy, 1'b0);
        chk("msg_len_5", msg_len, 8'h05);
        tick(3);
        exp_q.push_back({32'h11223344, 3'd4, 1'b0});
        exp_q.push_back({32'h55000000, 3'd1, 1'b1});
        compare_queues("basic");

        // Illegal lengths.
        base_len = n_len;
        send_byte(8'h00);
        chk("err_len_zero", {err_len, busy}, {1'b1, 1'b0});
        send_byte(8'h41);
        chk("err_len_big", {err_len, busy}, {1'b1, 1'b0});
        chk("msg_len_kept", msg_len, 8'h05);
        tick(2);
        chk("err_len_count", 64'(n_len - base_len), 64'd2);
        chk("err_len_no_word", 64'(got_q.size()), 64'd0);

        // Randomized messages, with boundary lengths and random stalls between strobes.
        lens[0] = 1;
        lens[1] = 4;
        lens[2] = 5;
        lens[3] = MAXL;
        for (int m = 4; m < 8; m++) lens[m] = int'($urandom_range(1, MAXL));
        base_abort = n_abort;
        for (int m = 0; m < 8; m++) begin
            len = lens[m];
            for (int i = 0; i < len; i++) payload[i] = 8'($urandom);
            model_msg(len);
            word_ready = 1'b1;
            send_byte(len[7:0]);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 3)) begin
                    word_ready = 1'($urandom_range(0, 1));
                    tick(1);
                end
                word_ready = 1'b1;
                send_byte(payload[i]);
            end
        end
        word_ready = 1'b1;
        tick(4);
        compare_queues("rand");
        chk("rand_msg_len", msg_len, 8'(lens[7]));
        chk("rand_no_abort", 64'(n_abort - base_abort), 64'd0);

        // A byte on the very cycle the timeout would fire wins.
        base_tmo = n_tmo;
        send_byte(8'h02);
        send_byte(8'hA1);
        tick(T - 1);
        send_byte(8'hB2);
        chk("byte_wins_word", {word_valid, word_data, word_bytes, word_last},
            {1'b1, 32'hA1B20000, 3'd2, 1'b1});
        tick(2);
        chk("byte_wins_no_tmo", 64'(n_tmo - base_tmo), 64'd0);
        got_q.delete();

        // Inter-byte timeout.
        send_byte(8'h08);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        k = 1;
        while (k <= int'(T) + 5) begin
            tick(1);
            if (err_timeout) break;
            k++;
        end
        chk("tmo_cycles", 64'(k), 64'(T));
        chk("tmo_abort", {word_abort, busy, word_valid}, {1'b1, 1'b0, 1'b0});
        send_byte(8'h03);
        send_byte(8'hC1);
        send_byte(8'hC2);
        send_byte(8'hC3);
        chk("tmo_recover", {word_valid, word_data, word_bytes, word_last},
            {1'b1, 32'hC1C2C300, 3'd3, 1'b1});
        tick(2);
        got_q.delete();

        // Overflow: consumer never ready.
        word_ready = 1'b0;
        base_ovf = n_ovf;
        send_byte(8'h08);
        for (int i = 0; i < 7; i++) begin
            send_byte(8'(8'hD0 + i));
            if (i >= 3)
                chk("ovf_hold", {word_valid, word_data, word_bytes, word_last},
                    {1'b1, 32'hD0D1D2D3, 3'd4, 1'b0});
        end
        send_byte(8'hD7);
        chk("ovf_pulse", {err_overflow, word_abort, word_valid, busy}, {4'b1100});
        tick(1);
        chk("ovf_single", {err_overflow, word_abort, word_valid}, 3'b000);
        chk("ovf_count", 64'(n_ovf - base_ovf), 64'd1);

        // Accept and load in the same cycle.
        base_ovf = n_ovf;
        got_q.delete();
        send_byte(8'h08);
        for (int i = 0; i < 7; i++) send_byte(8'(8'hE0 + i));
        word_ready = 1'b1;
        send_byte(8'hE7);
        chk("same_cycle_load", {word_valid, word_data, word_last}, {1'b1, 32'hE4E5E6E7, 1'b1});
        tick(3);
        exp_q.push_back({32'hE0E1E2E3, 3'd4, 1'b0});
        exp_q.push_back({32'hE4E5E6E7, 3'd4, 1'b1});
        compare_queues("same_cycle");
        chk("same_cycle_no_ovf", 64'(n_ovf - base_ovf), 64'd0);

        // Reset mid-message.
        base_abort = n_abort;
        send_byte(8'h05);
        send_byte(8'h77);
        send_byte(8'h88);
        reset = 1'b1;
        tick(1);
        chk("mid_reset_vals", {word_data, word_valid, word_last, word_bytes, msg_len, word_abort,
                               busy, err_len, err_timeout, err_overflow}, 64'd0);
        reset = 1'b0;
        send_byte(8'h02);
        send_byte(8'hAA);
        send_byte(8'hBB);
        chk("post_reset_word", {word_valid, word_data, word_bytes, word_last},
            {1'b1, 32'hAABB0000, 3'd2, 1'b1});
        tick(2);
        chk("reset_no_abort", 64'(n_abort - base_abort), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
